// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 Hz VGA raster generator.
// Totals must stay <= 1023 so that every coordinate fits in coord_t.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts on enable and wraps max back to 0.
// wrap is combinational so the next axis can chain off it in the same tick.
module vga_axis_counter
  import vga_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  coord_t max,
  output coord_t count,
  output logic   wrap
);

  assign wrap = en && (count == max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: x/y to the paint logic, colour/sync/blank registered together
// so every DAC pin changes on the same edge, half a pixel before vga_clk rises.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hsync_n,
  output logic       vga_vsync_n,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       frame_start
);

  localparam coord_t H_MAX  = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_MAX  = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  logic   pix_en;
  logic   h_wrap;
  logic   v_wrap;
  logic   v_en;
  coord_t hcount;
  coord_t vcount;

  logic   active_p0;
  logic   hsync_n_p0;
  logic   vsync_n_p0;
  rgb_t   rgb_p0;

  logic   hsync_n_p1;
  logic   vsync_n_p1;
  logic   blank_n_p1;
  logic   frame_p1;
  rgb_t   rgb_p1;

  // 25 MHz pixel tick: every other 50 MHz edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
    end
  end

  assign v_en = pix_en && h_wrap;

  vga_axis_counter u_h_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .max   (H_MAX),
    .count (hcount),
    .wrap  (h_wrap)
  );

  vga_axis_counter u_v_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v_en),
    .max   (V_MAX),
    .count (vcount),
    .wrap  (v_wrap)
  );

  // p0: decode of the current counters, colour returned by the paint logic.
  always_comb begin
    active_p0  = (hcount < H_ACT) && (vcount < V_ACT);
    hsync_n_p0 = !((hcount >= HS_BEG) && (hcount < HS_END));
    vsync_n_p0 = !((vcount >= VS_BEG) && (vcount < VS_END));
    rgb_p0     = '0;
    if (active_p0) begin
      rgb_p0 = '{r: red_in, g: green_in, b: blue_in};
    end
  end

  // p1: DAC-facing registers, all updated on the same tick edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_n_p1 <= 1'b1;
      vsync_n_p1 <= 1'b1;
      blank_n_p1 <= 1'b0;
      rgb_p1     <= '0;
    end else if (pix_en) begin
      hsync_n_p1 <= hsync_n_p0;
      vsync_n_p1 <= vsync_n_p0;
      blank_n_p1 <= active_p0;
      rgb_p1     <= rgb_p0;
    end
  end

  // pix_en is low on the following edge, so this is a single-clk pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_p1 <= 1'b0;
    end else begin
      frame_p1 <= pix_en && v_wrap;
    end
  end

  assign x           = hcount;
  assign y           = vcount;
  assign vga_r       = rgb_p1.r;
  assign vga_g       = rgb_p1.g;
  assign vga_b       = rgb_p1.b;
  assign vga_hsync_n = hsync_n_p1;
  assign vga_vsync_n = vsync_n_p1;
  assign vga_blank_n = blank_n_p1;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = pix_en;
  assign frame_start = frame_p1;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a small-raster instance exercised over several frames
// and a default 640x480 instance over a few lines, both against a raster model.
module tb_vga_timing_ctrl;

  localparam int S_HA = 20, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HT = 800;
  localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VT = 525;

  typedef struct packed {
    logic       hs_n;
    logic       vs_n;
    logic       blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } dac_t;

  typedef struct packed {
    int   hs_run;
    int   vs_run;
    int   ticks;
    int   last_fall;
    logic hs_prev;
    logic vs_prev;
  } stat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  logic [9:0] s_x, s_y, d_x, d_y;
  logic [7:0] s_ri, s_gi, s_bi, d_ri, d_gi, d_bi;
  logic [7:0] s_r, s_g, s_b, d_r, d_g, d_b;
  logic       s_hs, s_vs, s_bl, s_sy, s_vc, s_fs;
  logic       d_hs, d_vs, d_bl, d_sy, d_vc, d_fs;

  vga_timing_ctrl #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .x(s_x), .y(s_y),
    .red_in(s_ri), .green_in(s_gi), .blue_in(s_bi),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .vga_hsync_n(s_hs), .vga_vsync_n(s_vs), .vga_blank_n(s_bl),
    .vga_sync_n(s_sy), .vga_clk(s_vc), .frame_start(s_fs)
  );

  vga_timing_ctrl dut_d (
    .clk(clk), .rst_n(rst_n), .x(d_x), .y(d_y),
    .red_in(d_ri), .green_in(d_gi), .blue_in(d_bi),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .vga_hsync_n(d_hs), .vga_vsync_n(d_vs), .vga_blank_n(d_bl),
    .vga_sync_n(d_sy), .vga_clk(d_vc), .frame_start(d_fs)
  );

  int    checks = 0;
  int    errors = 0;
  int    s_h, s_v, d_h, d_v;
  int    cyc, s_last_fs, s_first_hs, cold_first_hs;
  logic  m_pix, red_ff, reached;
  dac_t  s_q[$];
  dac_t  d_q[$];
  stat_t s_st, d_st;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic dac_t expect_dac(input int h, input int v, input int ha, input int hf,
                                      input int hsw, input int va, input int vf, input int vsw,
                                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    dac_t e;
    logic act;
    act       = (h < ha) && (v < va);
    e.hs_n    = !((h >= ha + hf) && (h < ha + hf + hsw));
    e.vs_n    = !((v >= va + vf) && (v < va + vf + vsw));
    e.blank_n = act;
    e.r       = act ? r : 8'h00;
    e.g       = act ? g : 8'h00;
    e.b       = act ? b : 8'h00;
    return e;
  endfunction

  // Paint logic stand-in: colour is a known function of the current pixel.
  task automatic drive_inputs();
    red_ff = (cyc >= 2 * S_HT * S_VT) && (cyc < 4 * S_HT * S_VT);
    s_ri   = red_ff ? 8'hFF : s_h[7:0];
    s_gi   = s_v[7:0] ^ 8'h3C;
    s_bi   = 8'(s_h + 3 * s_v);
    d_ri   = d_h[7:0];
    d_gi   = 8'h5A;
    d_bi   = d_h[9:2];
  endtask

  task automatic model_reset();
    s_h = 0; s_v = 0; d_h = 0; d_v = 0;
    m_pix = 1'b0;
    cyc = 0; s_last_fs = 0; s_first_hs = -1;
    s_q.delete(); d_q.delete();
    s_st = '{hs_run: 0, vs_run: 0, ticks: 0, last_fall: -1, hs_prev: 1'b1, vs_prev: 1'b1};
    d_st = s_st;
    drive_inputs();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s"}, {s_x, s_y, s_hs, s_vs, s_bl, s_r, s_g, s_b, s_fs, s_vc, s_sy},
        {20'd0, 3'b110, 24'd0, 3'b000});
    chk({tag, "_d"}, {d_x, d_y, d_hs, d_vs, d_bl, d_r, d_g, d_b, d_fs, d_vc, d_sy},
        {20'd0, 3'b110, 24'd0, 3'b000});
  endtask

  // h, v are the coordinates whose decode is now on the DAC pins.
  task automatic sync_stats(input string tag, input logic hs, input logic vs, input int h,
                            input int v, input int ha, input int hf, input int hsw, input int ht,
                            input int va, input int vf, input int vsw, inout stat_t st);
    st.ticks++;
    if (!hs) begin
      if (st.hs_prev) begin
        chk({tag, "_hs_first_pos"}, h, ha + hf);
        if (st.last_fall >= 0) chk({tag, "_line_len"}, st.ticks - st.last_fall, ht);
        st.last_fall = st.ticks;
      end
      st.hs_run++;
    end else begin
      if (!st.hs_prev) chk({tag, "_hs_width"}, st.hs_run, hsw);
      st.hs_run = 0;
    end
    if (!vs) begin
      if (st.vs_prev) chk({tag, "_vs_first_pos"}, {h, v}, {32'd0, 32'(va + vf)});
      st.vs_run++;
    end else begin
      if (!st.vs_prev) chk({tag, "_vs_width"}, st.vs_run, vsw * ht);
      st.vs_run = 0;
    end
    st.hs_prev = hs;
    st.vs_prev = vs;
  endtask

  task automatic cycle();
    logic tick;
    dac_t e;
    tick = m_pix;
    if (tick) begin
      s_q.push_back(expect_dac(s_h, s_v, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, s_ri, s_gi, s_bi));
      d_q.push_back(expect_dac(d_h, d_v, D_HA, D_HF, D_HS, D_VA, D_VF, D_VS, d_ri, d_gi, d_bi));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (tick) begin
      e = s_q.pop_front();
      chk("s_dac", {s_hs, s_vs, s_bl, s_r, s_g, s_b}, e);
      e = d_q.pop_front();
      chk("d_dac", {d_hs, d_vs, d_bl, d_r, d_g, d_b}, e);
      if (s_v >= S_VA) chk("s_vblank_dark", {s_bl, s_r}, 9'd0);
      sync_stats("s", s_hs, s_vs, s_h, s_v, S_HA, S_HF, S_HS, S_HT, S_VA, S_VF, S_VS, s_st);
      sync_stats("d", d_hs, d_vs, d_h, d_v, D_HA, D_HF, D_HS, D_HT, D_VA, D_VF, D_VS, d_st);
      chk("s_frame_start", s_fs, (s_h == S_HT - 1) && (s_v == S_VT - 1));
      chk("d_frame_start", d_fs, (d_h == D_HT - 1) && (d_v == D_VT - 1));
      if (s_h == S_HT - 1) begin
        s_h = 0;
        s_v = (s_v == S_VT - 1) ? 0 : s_v + 1;
      end else begin
        s_h++;
      end
      if (d_h == D_HT - 1) begin
        d_h = 0;
        d_v = (d_v == D_VT - 1) ? 0 : d_v + 1;
      end else begin
        d_h++;
      end
    end else begin
      chk("s_frame_start", s_fs, 1'b0);
      chk("d_frame_start", d_fs, 1'b0);
    end
    if (s_fs) begin
      chk("s_frame_len", cyc - s_last_fs, 2 * S_HT * S_VT);
      s_last_fs = cyc;
    end
    if (!s_hs && s_first_hs < 0) s_first_hs = cyc;
    m_pix = !m_pix;
    chk("s_xy", {s_x, s_y}, {10'(s_h), 10'(s_v)});
    chk("d_xy", {d_x, d_y}, {10'(d_h), 10'(d_v)});
    chk("clk_sync_pins", {s_vc, d_vc, s_sy, d_sy}, {m_pix, m_pix, 2'b00});
    drive_inputs();
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #4 check_reset("cold_rst");
    repeat (3) begin
      @(posedge clk);
      #1 check_reset("cold_hold");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5000; i++) cycle();
    cold_first_hs = s_first_hs;
    chk("cold_first_hs", s_first_hs, 2 * (S_HA + S_HF + 1));

    reached = 1'b0;
    for (int i = 0; i < 4 * S_HT * S_VT; i++) begin
      if (s_h == 20 && s_v == 5) begin
        reached = 1'b1;
        break;
      end
      cycle();
    end
    chk("reach_mid_line", reached, 1'b1);

    // Asynchronous reset between clock edges, mid-line.
    #4 rst_n = 1'b0;
    #1 check_reset("mid_rst_async");
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1 check_reset("mid_hold");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2000; i++) cycle();
    chk("warm_first_hs", s_first_hs, cold_first_hs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
